// File: rtl/dispatch_ctrl_pkg.sv
// Shared types and default sizing for the dispatch stage between rename and
// the ALU / branch / LSU reservation stations.
package dispatch_ctrl_pkg;

  typedef enum logic [1:0] {
    FU_ALU = 2'b00,
    FU_BR  = 2'b01,
    FU_LSU = 2'b10,
    FU_RSV = 2'b11
  } fu_type_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } hold_state_e;

  localparam int unsigned PREG_W           = 7;
  localparam int unsigned ROB_TAG_W        = 4;
  localparam int unsigned DEF_UOP_W        = 80;
  localparam int unsigned DEF_ALU_RS_DEPTH = 8;
  localparam int unsigned DEF_BR_RS_DEPTH  = 4;
  localparam int unsigned DEF_LSU_RS_DEPTH = 8;
  localparam int unsigned DEF_ROB_DEPTH    = 16;
  localparam int unsigned STALL_W          = 16;

  // Reserved futype has no dedicated station; it is executed by the ALU.
  function automatic fu_type_e route_fu(input logic [1:0] fu);
    return (fu == 2'b11) ? FU_ALU : fu_type_e'(fu);
  endfunction

endpackage

// File: rtl/dispatch_ctrl_if.sv
// Rename-side handshake plus reservation-station write / credit-return bus.
interface dispatch_ctrl_if #(
  parameter int unsigned UOP_W = dispatch_ctrl_pkg::DEF_UOP_W
);

  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_futype;
  logic [UOP_W-1:0] in_uop;

  logic             alu_valid;
  logic             br_valid;
  logic             lsu_valid;
  logic [UOP_W-1:0] rs_uop;

  logic             alu_issue;
  logic             br_issue;
  logic             lsu_issue;
  logic             rob_commit;
  logic             flush;

  // Dispatch stage side.
  modport master (
    input  in_valid, in_futype, in_uop,
    input  alu_issue, br_issue, lsu_issue, rob_commit, flush,
    output in_ready, alu_valid, br_valid, lsu_valid, rs_uop
  );

  // Rename / RS / ROB side.
  modport slave (
    output in_valid, in_futype, in_uop,
    output alu_issue, br_issue, lsu_issue, rob_commit, flush,
    input  in_ready, alu_valid, br_valid, lsu_valid, rs_uop
  );

endinterface

// File: rtl/dispatch_ctrl_credit_counter.sv
// Free-slot credit counter: starts full, spends on dispatch, refills on
// issue/commit, and snaps back to full when the downstream queue flushes.
module dispatch_ctrl_credit_counter #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          dec,
  input  logic          inc,
  input  logic          flush,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_d;

  // Equal dec and inc cancel; a return at full is dropped rather than wrapping.
  always_comb begin
    count_d = count;
    if (flush) begin
      count_d = CW'(DEPTH);
    end else if (inc && !dec) begin
      if (count != CW'(DEPTH)) count_d = count + CW'(1);
    end else if (dec && !inc) begin
      if (count != '0) count_d = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count <= CW'(DEPTH);
    else        count <= count_d;
  end

  credit_return_at_full: assert property (
    @(posedge clk) disable iff (!rst_n)
      !(inc && !dec && !flush && (count == CW'(DEPTH))))
    else $warning("%m: credit returned while counter already at depth");

endmodule

// File: rtl/dispatch_ctrl.sv
// One-entry dispatch hold register that steers a renamed uop to the ALU,
// branch or LSU reservation station once both RS and ROB credit exist.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int unsigned ALU_RS_DEPTH = DEF_ALU_RS_DEPTH,
  parameter int unsigned BR_RS_DEPTH  = DEF_BR_RS_DEPTH,
  parameter int unsigned LSU_RS_DEPTH = DEF_LSU_RS_DEPTH,
  parameter int unsigned ROB_DEPTH    = DEF_ROB_DEPTH,
  parameter int unsigned UOP_W        = DEF_UOP_W
) (
  input  logic                clk,
  input  logic                reset,
  dispatch_ctrl_if.master     bus,
  output logic [STALL_W-1:0]  stall_rs_cnt,
  output logic [STALL_W-1:0]  stall_rob_cnt
);

  localparam int unsigned ALU_CW = $clog2(ALU_RS_DEPTH + 1);
  localparam int unsigned BR_CW  = $clog2(BR_RS_DEPTH + 1);
  localparam int unsigned LSU_CW = $clog2(LSU_RS_DEPTH + 1);
  localparam int unsigned ROB_CW = $clog2(ROB_DEPTH + 1);

  hold_state_e      state_q;
  hold_state_e      state_d;
  fu_type_e         hold_fu_q;
  logic [UOP_W-1:0] hold_uop_q;

  logic [ALU_CW-1:0] alu_cnt;
  logic [BR_CW-1:0]  br_cnt;
  logic [LSU_CW-1:0] lsu_cnt;
  logic [ROB_CW-1:0] rob_cnt;

  logic hold_valid;
  logic sel_nz;
  logic rob_nz;
  logic fire;
  logic ready;
  logic accept;
  logic alu_fire;
  logic br_fire;
  logic lsu_fire;
  logic stall_rs;
  logic stall_rob;

  assign hold_valid = (state_q == ST_HELD);
  assign rob_nz     = (rob_cnt != '0);

  // Credit of the station the held uop is headed for.
  always_comb begin
    sel_nz = (alu_cnt != '0);
    unique case (hold_fu_q)
      FU_BR:   sel_nz = (br_cnt != '0);
      FU_LSU:  sel_nz = (lsu_cnt != '0);
      default: sel_nz = (alu_cnt != '0);
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  // Flush wins over everything; a fire with a same-cycle accept stays HELD.
  always_comb begin
    state_d = state_q;
    fire    = hold_valid & sel_nz & rob_nz & ~bus.flush;
    ready   = ~bus.flush & (~hold_valid | fire);
    accept  = bus.in_valid & ready;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = ST_HELD;
      end
      ST_HELD: begin
        if (bus.flush)            state_d = ST_EMPTY;
        else if (fire && !accept) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_fu_q  <= FU_ALU;
      hold_uop_q <= '0;
    end else if (accept) begin
      hold_fu_q  <= route_fu(bus.in_futype);
      hold_uop_q <= bus.in_uop;
    end
  end

  assign alu_fire = fire & (hold_fu_q == FU_ALU);
  assign br_fire  = fire & (hold_fu_q == FU_BR);
  assign lsu_fire = fire & (hold_fu_q == FU_LSU);

  assign bus.in_ready  = ready;
  assign bus.alu_valid = alu_fire;
  assign bus.br_valid  = br_fire;
  assign bus.lsu_valid = lsu_fire;
  assign bus.rs_uop    = hold_uop_q;

  dispatch_ctrl_credit_counter #(.DEPTH(ALU_RS_DEPTH)) u_alu_credit (
    .clk   (clk),
    .rst_n (reset),
    .dec   (alu_fire),
    .inc   (bus.alu_issue),
    .flush (bus.flush),
    .count (alu_cnt)
  );

  dispatch_ctrl_credit_counter #(.DEPTH(BR_RS_DEPTH)) u_br_credit (
    .clk   (clk),
    .rst_n (reset),
    .dec   (br_fire),
    .inc   (bus.br_issue),
    .flush (bus.flush),
    .count (br_cnt)
  );

  dispatch_ctrl_credit_counter #(.DEPTH(LSU_RS_DEPTH)) u_lsu_credit (
    .clk   (clk),
    .rst_n (reset),
    .dec   (lsu_fire),
    .inc   (bus.lsu_issue),
    .flush (bus.flush),
    .count (lsu_cnt)
  );

  dispatch_ctrl_credit_counter #(.DEPTH(ROB_DEPTH)) u_rob_credit (
    .clk   (clk),
    .rst_n (reset),
    .dec   (fire),
    .inc   (bus.rob_commit),
    .flush (bus.flush),
    .count (rob_cnt)
  );

  // RS starvation is reported ahead of ROB starvation; the two never overlap.
  assign stall_rs  = hold_valid & ~sel_nz;
  assign stall_rob = hold_valid & sel_nz & ~rob_nz;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_rs_cnt  <= '0;
      stall_rob_cnt <= '0;
    end else begin
      if (stall_rs && (stall_rs_cnt != '1))   stall_rs_cnt  <= stall_rs_cnt + STALL_W'(1);
      if (stall_rob && (stall_rob_cnt != '1)) stall_rob_cnt <= stall_rob_cnt + STALL_W'(1);
    end
  end

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed, table-driven check of dispatch_ctrl steering, credits, stalls and flush.
module tb_dispatch_ctrl;
  import dispatch_ctrl_pkg::*;

  localparam int P_AI = 8;
  localparam int P_BI = 4;
  localparam int P_LI = 2;
  localparam int P_RC = 1;
  localparam int V_ALU = 4;
  localparam int V_BR  = 2;
  localparam int V_LSU = 1;

  typedef struct {
    logic        iv;
    logic [1:0]  fu;
    logic [7:0]  u;
    logic [3:0]  p;
    logic        fl;
    logic        er;
    logic [2:0]  ev;
    logic [7:0]  eu;
    logic [15:0] esr;
    logic [15:0] esb;
  } vec_t;

  logic clk;
  logic reset;
  logic [15:0] stall_rs_cnt;
  logic [15:0] stall_rob_cnt;
  int n_chk;
  int n_err;
  vec_t tv[$];

  dispatch_ctrl_if #(.UOP_W(80)) bus ();

  dispatch_ctrl u_dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .stall_rs_cnt  (stall_rs_cnt),
    .stall_rob_cnt (stall_rob_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [79:0] mkuop(input logic [7:0] x);
    return {{8{x}}, 16'hF00D};
  endfunction

  function automatic vec_t mk(input int iv, input int fu, input int u, input int p,
                              input int fl, input int er, input int ev, input int eu,
                              input int esr, input int esb);
    vec_t r;
    r.iv  = 1'(iv);
    r.fu  = 2'(fu);
    r.u   = 8'(u);
    r.p   = 4'(p);
    r.fl  = 1'(fl);
    r.er  = 1'(er);
    r.ev  = 3'(ev);
    r.eu  = 8'(eu);
    r.esr = 16'(esr);
    r.esb = 16'(esb);
    return r;
  endfunction

  task automatic chk(input string name, input int row, input logic [79:0] act,
                     input logic [79:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic build_table();
    // ALU burst: 8 dispatch, 9th stalls on RS credit, one issue releases it.
    tv.push_back(mk(1, FU_ALU, 1, 0, 0, 1, 0, 0, 0, 0));
    for (int k = 1; k <= 8; k++) tv.push_back(mk(1, FU_ALU, k + 1, 0, 0, 1, V_ALU, k, 0, 0));
    tv.push_back(mk(1, FU_ALU, 10, 0,    0, 0, 0, 0, 0, 0));
    tv.push_back(mk(1, FU_ALU, 10, 0,    0, 0, 0, 0, 1, 0));
    tv.push_back(mk(1, FU_ALU, 10, P_AI, 0, 0, 0, 0, 2, 0));
    tv.push_back(mk(0, FU_ALU, 0,  0,    0, 1, V_ALU, 9, 3, 0));
    tv.push_back(mk(0, FU_ALU, 0,  0,    1, 0, 0, 0, 3, 0));
    // Branch stream with a credit returned every cycle: no stall.
    tv.push_back(mk(1, FU_BR, 'h20, 0, 0, 1, 0, 0, 3, 0));
    tv.push_back(mk(1, FU_BR, 'h21, 0, 0, 1, V_BR, 'h20, 3, 0));
    for (int k = 2; k <= 5; k++) tv.push_back(mk(1, FU_BR, 'h20 + k, P_BI, 0, 1, V_BR, 'h20 + k - 1, 3, 0));
    tv.push_back(mk(0, FU_BR,  0, P_BI, 0, 1, V_BR, 'h25, 3, 0));
    tv.push_back(mk(0, FU_BR,  0, P_BI, 0, 1, 0, 0, 3, 0));
    tv.push_back(mk(0, FU_ALU, 0, 0,    1, 0, 0, 0, 3, 0));
    // 16 mixed ALU/LSU exhaust the ROB; a branch then stalls on ROB credit.
    tv.push_back(mk(1, FU_ALU, 'h40, 0, 0, 1, 0, 0, 3, 0));
    for (int k = 1; k <= 15; k++)
      tv.push_back(mk(1, (k % 2 == 1) ? FU_LSU : FU_ALU, 'h40 + k, 0, 0, 1,
                      ((k - 1) % 2 == 1) ? V_LSU : V_ALU, 'h40 + k - 1, 3, 0));
    tv.push_back(mk(1, FU_BR, 'h50, 0,    0, 1, V_LSU, 'h4F, 3, 0));
    tv.push_back(mk(1, FU_BR, 'h51, 0,    0, 0, 0, 0, 3, 0));
    tv.push_back(mk(1, FU_BR, 'h51, 0,    0, 0, 0, 0, 3, 1));
    tv.push_back(mk(1, FU_BR, 'h51, P_RC, 0, 0, 0, 0, 3, 2));
    tv.push_back(mk(0, FU_BR, 0,    0,    0, 1, V_BR, 'h50, 3, 3));
    tv.push_back(mk(0, FU_BR, 0,    0,    1, 0, 0, 0, 3, 3));
    // Stalled branch flushed; issue pulses during the flush are ignored.
    tv.push_back(mk(1, FU_BR, 'h60, 0, 0, 1, 0, 0, 3, 3));
    for (int k = 1; k <= 4; k++) tv.push_back(mk(1, FU_BR, 'h60 + k, 0, 0, 1, V_BR, 'h60 + k - 1, 3, 3));
    tv.push_back(mk(1, FU_BR, 'h65, 0,           0, 0, 0, 0, 3, 3));
    tv.push_back(mk(1, FU_BR, 'h65, P_AI | P_BI, 1, 0, 0, 0, 4, 3));
    tv.push_back(mk(1, FU_BR, 'h66, 0,           0, 1, 0, 0, 5, 3));
    tv.push_back(mk(0, FU_BR, 0,    0,           1, 0, 0, 0, 5, 3));
    tv.push_back(mk(0, FU_BR, 0,    0,           0, 1, 0, 0, 5, 3));
    // Reserved futype goes to ALU and spends ALU credit; fire+issue at credit 1.
    tv.push_back(mk(1, FU_RSV, 'h70, 0, 0, 1, 0, 0, 5, 3));
    tv.push_back(mk(0, FU_ALU, 0,    0, 0, 1, V_ALU, 'h70, 5, 3));
    tv.push_back(mk(1, FU_ALU, 'h71, 0, 0, 1, 0, 0, 5, 3));
    for (int k = 2; k <= 7; k++) tv.push_back(mk(1, FU_ALU, 'h70 + k, 0, 0, 1, V_ALU, 'h70 + k - 1, 5, 3));
    tv.push_back(mk(1, FU_ALU, 'h78, P_AI, 0, 1, V_ALU, 'h77, 5, 3));
    tv.push_back(mk(0, FU_ALU, 0,    0,    0, 1, V_ALU, 'h78, 5, 3));
    tv.push_back(mk(1, FU_ALU, 'h79, 0,    0, 1, 0, 0, 5, 3));
    tv.push_back(mk(0, FU_ALU, 0,    0,    0, 0, 0, 0, 5, 3));
    tv.push_back(mk(0, FU_ALU, 0,    P_AI, 0, 0, 0, 0, 6, 3));
    tv.push_back(mk(0, FU_ALU, 0,    0,    0, 1, V_ALU, 'h79, 7, 3));
    tv.push_back(mk(0, FU_ALU, 0,    0,    1, 0, 0, 0, 7, 3));
    // Issue at full ALU credit must not raise it above 8.
    tv.push_back(mk(0, FU_ALU, 0,    P_AI, 0, 1, 0, 0, 7, 3));
    tv.push_back(mk(1, FU_ALU, 'h80, 0,    0, 1, 0, 0, 7, 3));
    for (int k = 1; k <= 8; k++) tv.push_back(mk(1, FU_ALU, 'h80 + k, 0, 0, 1, V_ALU, 'h80 + k - 1, 7, 3));
    tv.push_back(mk(0, FU_ALU, 0, 0, 0, 0, 0, 0, 7, 3));
    tv.push_back(mk(0, FU_ALU, 0, 0, 0, 0, 0, 0, 8, 3));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_futype  = 2'b00;
    bus.in_uop     = '0;
    bus.alu_issue  = 1'b0;
    bus.br_issue   = 1'b0;
    bus.lsu_issue  = 1'b0;
    bus.rob_commit = 1'b0;
    bus.flush      = 1'b0;
    build_table();

    #2;
    chk("reset_ready",     -1, 80'(bus.in_ready), 80'(1));
    chk("reset_valids",    -1, 80'({bus.alu_valid, bus.br_valid, bus.lsu_valid}), 80'(0));
    chk("reset_rs_uop",    -1, bus.rs_uop, 80'(0));
    chk("reset_stall_rs",  -1, 80'(stall_rs_cnt), 80'(0));
    chk("reset_stall_rob", -1, 80'(stall_rob_cnt), 80'(0));

    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tv.size(); i++) begin
      bus.in_valid  = tv[i].iv;
      bus.in_futype = tv[i].fu;
      bus.in_uop    = mkuop(tv[i].u);
      {bus.alu_issue, bus.br_issue, bus.lsu_issue, bus.rob_commit} = tv[i].p;
      bus.flush     = tv[i].fl;
      #4;
      chk("in_ready",  i, 80'(bus.in_ready), 80'(tv[i].er));
      chk("rs_valids", i, 80'({bus.alu_valid, bus.br_valid, bus.lsu_valid}), 80'(tv[i].ev));
      if (tv[i].ev != 3'b000) chk("rs_uop", i, bus.rs_uop, mkuop(tv[i].eu));
      chk("stall_rs_cnt",  i, 80'(stall_rs_cnt),  80'(tv[i].esr));
      chk("stall_rob_cnt", i, 80'(stall_rob_cnt), 80'(tv[i].esb));
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dispatch_ctrl.md
Name: dispatch_ctrl

Overview:
Sits between rename (plus its output skid buffer) and the three reservation stations (ALU, branch, LSU). Holds one renamed uop in an output register and steers it by FUtype to the matching RS. Tracks free RS slots and free ROB entries with credit counters, and back-pressures rename when the target has no credit. Flushes on branch mispredict.

Parameters:
ALU_RS_DEPTH, 8, ALU reservation-station entries (initial ALU credits)
BR_RS_DEPTH, 4, branch RS entries
LSU_RS_DEPTH, 8, load/store RS entries
ROB_DEPTH, 16, ROB entries (initial ROB credits)
UOP_W, 80, width of opaque renamed-uop payload (prs1/prs2/prd/old_prd/rob_tag/imm/ctrl)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  renamed uop valid
in_ready  out  1  dispatch can accept uop
in_futype  in  2  00 ALU, 01 branch, 10 LSU, 11 reserved
in_uop  in  UOP_W  payload, passed through untouched
alu_valid  out  1  write uop into ALU RS this cycle
br_valid  out  1  write uop into branch RS this cycle
lsu_valid  out  1  write uop into LSU RS this cycle
rs_uop  out  UOP_W  payload shared by all three RS
alu_issue  in  1  ALU RS freed one entry (credit return)
br_issue  in  1  branch RS freed one entry
lsu_issue  in  1  LSU RS freed one entry
rob_commit  in  1  ROB retired one entry (credit return)
flush  in  1  branch mispredict: squash
stall_rs_cnt  out  16  saturating count of cycles blocked on RS credit
stall_rob_cnt  out  16  saturating count of cycles blocked on ROB credit

Behaviour:
- Reset (reset=0, async): hold_valid=0, alu/br/lsu_valid=0, rs_uop=0, credits = respective DEPTH, rob credits = ROB_DEPTH, stall counters = 0, in_ready=1 once reset releases.
- Hold register: captures {in_futype, in_uop} on accept (in_valid & in_ready). Futype 11 is stored as 00 (routed to ALU).
- sel_credit = credit of RS selected by held futype. fire = hold_valid & sel_credit!=0 & rob_credit!=0.
- Exactly one of alu/br/lsu_valid = fire & (held futype matches); rs_uop = held payload. No RS ready; credits guarantee space. RS must write on valid.
- in_ready = ~flush & (~hold_valid | fire). Back-to-back uops dispatch at 1/cycle when credits allow. Latency: accept in cycle N -> RS valid in cycle N+1 at earliest.
- hold_valid next = accept ? 1 : (fire ? 0 : hold_valid).
- Credit update per counter: next = cur - (fire to this RS) + issue pulse. Simultaneous decrement and increment leaves it unchanged. ROB: next = cur - fire + rob_commit.
- Credit return while at DEPTH is a protocol error: counter saturates at DEPTH, with an assertion in simulation. Decrement at 0 is impossible by construction.
- Counter widths: $clog2(DEPTH+1).
- Stall counters: stall_rs_cnt++ when hold_valid & sel_credit==0. stall_rob_cnt++ when hold_valid & sel_credit!=0 & rob_credit==0. Both saturate at 0xFFFF. Neither clears on flush.
- Flush (synchronous, cycle F): outputs still computed combinationally but fire forced 0. in_ready=0; input ignored. At F+1: hold_valid=0, all RS and ROB credits = DEPTH (RS/ROB also flush). Issue/commit pulses during F are ignored.
- No FSM beyond hold_valid. States: EMPTY (hold_valid=0), HELD (hold_valid=1). EMPTY->HELD on accept. HELD->EMPTY on fire without accept, or on flush. HELD->HELD on fire+accept, or on stall.

Decomposition:
- Shared package ooo_pkg: FUtype enum (FU_ALU=2'b00, FU_BR=2'b01, FU_LSU=2'b10, FU_RSV=2'b11), PREG_W=7, ROB_TAG_W=4, default depths.
- One sub-module, credit_counter (params DEPTH; inputs dec, inc, flush; output count/nonzero), instantiated 4×.

Test Plan:
- Reset, then 8 ALU uops back-to-back, no issue -> alu_valid pulses 8 consecutive cycles; 9th holds, in_ready=0, stall_rs_cnt increments each cycle; one alu_issue -> 9th dispatches next cycle.
- Branch uops with br_issue asserted every cycle after first -> credit stays at 3 or 4, 1 uop/cycle sustained, no stall.
- 16 mixed ALU/LSU uops, no rob_commit -> 17th stalls with stall_rob_cnt counting (stall_rs_cnt unchanged); rob_commit pulse -> it dispatches.
- Held uop stalled, flush asserted -> no valid output that cycle, in_ready=0; next cycle hold empty, all credits back to 8/4/8/16, in_ready=1.
- Futype 11 uop -> appears on alu_valid, consumes ALU credit.
- Simultaneous fire and alu_issue at ALU credit 1 -> credit stays 1; alu_issue at credit 8 -> stays 8, assertion fires.
